rinv_qt_mult: RTL and testbench

RINV_QT_MULT -- requirements
Module: rinv_qt_mult

---
 rtl/rinv_qt_mult.sv | 113 +++++++++++
 tb/tb_rinv_qt_mult.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rinv_qt_mult.sv
// rinv_qt_mult: sequential A^-1 = R^-1 * Q^T using one shared signed multiplier
module rinv_qt_mult #(
  parameter int WORD_LENGTH     = 16,
  parameter int FRACTION_LENGTH = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [WORD_LENGTH-1:0] inv_a11,
  input  logic signed [WORD_LENGTH-1:0] inv_a12,
  input  logic signed [WORD_LENGTH-1:0] inv_a13,
  input  logic signed [WORD_LENGTH-1:0] inv_a22,
  input  logic signed [WORD_LENGTH-1:0] inv_a23,
  input  logic signed [WORD_LENGTH-1:0] inv_a33,
  input  logic signed [WORD_LENGTH-1:0] q11,
  input  logic signed [WORD_LENGTH-1:0] q12,
  input  logic signed [WORD_LENGTH-1:0] q13,
  input  logic signed [WORD_LENGTH-1:0] q21,
  input  logic signed [WORD_LENGTH-1:0] q22,
  input  logic signed [WORD_LENGTH-1:0] q23,
  input  logic signed [WORD_LENGTH-1:0] q31,
  input  logic signed [WORD_LENGTH-1:0] q32,
  input  logic signed [WORD_LENGTH-1:0] q33,
  input  logic                          valid,
  input  logic                          err_in,
  output logic signed [WORD_LENGTH-1:0] ainv11,
  output logic signed [WORD_LENGTH-1:0] ainv12,
  output logic signed [WORD_LENGTH-1:0] ainv13,
  output logic signed [WORD_LENGTH-1:0] ainv21,
  output logic signed [WORD_LENGTH-1:0] ainv22,
  output logic signed [WORD_LENGTH-1:0] ainv23,
  output logic signed [WORD_LENGTH-1:0] ainv31,
  output logic signed [WORD_LENGTH-1:0] ainv32,
  output logic signed [WORD_LENGTH-1:0] ainv33,
  output logic                          done,
  output logic                          busy,
  output logic                          Error
);
  localparam int W  = WORD_LENGTH;
  localparam int AW = 2 * W + 2;
  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;
  state_t state;
  logic signed [W-1:0]   ra  [6];
  logic signed [W-1:0]   rq  [9];
  logic signed [W-1:0]   res [9];
  logic                  err_l, sat;
  logic [4:0]            step;
  logic signed [AW-1:0]  acc;
  logic [1:0]            col, kk, row;
  logic [2:0]            pp;
  logic [3:0]            qi, ri;
  logic                  last, ov;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  sum, sh;
  logic signed [W-1:0]   fin;
  // Step s -> column s/6, and within a column the 6 products follow the
  // packed R^-1 order a11,a12,a13,a22,a23,a33, so pp indexes ra directly.
  assign col  = step >= 5'd12 ? 2'd2 : step >= 5'd6 ? 2'd1 : 2'd0;
  assign pp   = 3'(step - 5'd6 * {3'd0, col});
  assign kk   = pp == 3'd0 ? 2'd0 : (pp == 3'd1 || pp == 3'd3) ? 2'd1 : 2'd2;
  assign row  = pp < 3'd3 ? 2'd0 : pp < 3'd5 ? 2'd1 : 2'd2;
  assign last = pp == 3'd2 || pp == 3'd4 || pp == 3'd5;
  assign qi   = {2'd0, col} * 4'd3 + {2'd0, kk};
  assign ri   = {2'd0, row} * 4'd3 + {2'd0, col};
  assign prod = ra[pp] * rq[qi];
  assign sum  = acc + AW'(prod);
  assign sh   = sum >>> FRACTION_LENGTH;
  // Saturate when the bits above the result sign are not a pure sign extension.
  assign ov   = !(&sh[AW-1:W-1] || !(|sh[AW-1:W-1]));
  assign fin  = ov ? (sh[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : sh[W-1:0];
  assign busy = state != IDLE;
  // Control FSM, operand capture, multiply-accumulate and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      acc   <= '0;
      sat   <= 1'b0;
      err_l <= 1'b0;
      done  <= 1'b0;
      Error <= 1'b0;
      for (int n = 0; n < 9; n++) res[n] <= '0;
      {ainv11, ainv12, ainv13, ainv21, ainv22, ainv23, ainv31, ainv32, ainv33} <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (valid) begin
          ra    <= '{inv_a11, inv_a12, inv_a13, inv_a22, inv_a23, inv_a33};
          rq    <= '{q11, q12, q13, q21, q22, q23, q31, q32, q33};
          err_l <= err_in;
          acc   <= '0;
          sat   <= 1'b0;
          step  <= '0;
          state <= CALC;
        end
        CALC: begin
          acc   <= last ? '0 : sum;
          if (last) res[ri] <= fin;
          sat   <= sat | (last & ov);
          step  <= step == 5'd17 ? 5'd0 : step + 5'd1;
          state <= step == 5'd17 ? WRITE : CALC;
        end
        WRITE: begin
          {ainv11, ainv12, ainv13, ainv21, ainv22, ainv23, ainv31, ainv32, ainv33} <=
            {res[0], res[1], res[2], res[3], res[4], res[5], res[6], res[7], res[8]};
          Error <= err_l | sat;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rinv_qt_mult.sv
// tb_rinv_qt_mult: directed and random checks of rinv_qt_mult against a matrix model
module tb_rinv_qt_mult;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, err_in = 1'b0;
  logic signed [15:0] ia [6];
  logic signed [15:0] qa [9];
  logic signed [15:0] ao [9];
  logic done, busy, Error;
  int checks = 0, errors = 0;
  int expv [9];
  int exp_err;
  int n;

  always #5 clk = ~clk;

  rinv_qt_mult dut (
    .clk(clk), .rst(rst),
    .inv_a11(ia[0]), .inv_a12(ia[1]), .inv_a13(ia[2]),
    .inv_a22(ia[3]), .inv_a23(ia[4]), .inv_a33(ia[5]),
    .q11(qa[0]), .q12(qa[1]), .q13(qa[2]),
    .q21(qa[3]), .q22(qa[4]), .q23(qa[5]),
    .q31(qa[6]), .q32(qa[7]), .q33(qa[8]),
    .valid(valid), .err_in(err_in),
    .ainv11(ao[0]), .ainv12(ao[1]), .ainv13(ao[2]),
    .ainv21(ao[3]), .ainv22(ao[4]), .ainv23(ao[5]),
    .ainv31(ao[6]), .ainv32(ao[7]), .ainv33(ao[8]),
    .done(done), .busy(busy), .Error(Error)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int tidx(input int i, input int k);
    return i == 0 ? k : i == 1 ? k + 2 : 5;
  endfunction

  // A^-1(i,j) = sum_k Rinv(i,k) * Q(j,k), floored by 2^12, saturated to 16 bits.
  task automatic calc_exp();
    longint s;
    exp_err = int'(err_in);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = i; k < 3; k++) s += longint'(ia[tidx(i, k)]) * longint'(qa[j*3+k]);
        s = s >>> 12;
        if (s > 32767) begin s = 32767; exp_err = 1; end
        else if (s < -32768) begin s = -32768; exp_err = 1; end
        expv[i*3+j] = int'(s);
      end
  endtask

  task automatic chk_out(input string tag);
    for (int e = 0; e < 9; e++)
      chk($sformatf("%s_ainv%0d%0d", tag, e / 3 + 1, e % 3 + 1), int'(ao[e]), expv[e]);
    chk({tag, "_Error"}, int'(Error), exp_err);
  endtask

  task automatic wait_done();
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 6; i++) ia[i] = $signed(16'($urandom)) >>> $urandom_range(0, 5);
    for (int i = 0; i < 9; i++) qa[i] = $signed(16'($urandom)) >>> $urandom_range(0, 5);
    err_in = ($urandom_range(0, 3) == 0);
  endtask

  task automatic txn(input string tag);
    calc_exp();
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    chk({tag, "_busy"}, int'(busy), 1);
    n = 0;
    wait_done();
    chk({tag, "_latency"}, n, 19);
    chk_out(tag);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, int'(done), 0);
    chk({tag, "_hold"}, int'(ao[0]), expv[0]);
  endtask

  initial begin
    ia = '{default: 16'sd0};
    qa = '{default: 16'sd0};
    valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    valid = 1'b0;
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_Error", int'(Error), 0);
    chk("rst_ainv11", int'(ao[0]), 0);

    ia = '{16'h1000, 0, 0, 16'h1000, 0, 16'h1000};
    qa = '{16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0, 16'h1000};
    txn("ident");

    ia = '{16'h1000, 0, 0, 16'h1000, 0, 16'h1000};
    qa = '{0, 16'h1000, 0, 0, 0, 16'h1000, 16'h1000, 0, 0};
    txn("perm");

    ia = '{16'h2000, 16'h0800, 16'hF000, 16'h1000, 16'h0400, 16'h0800};
    qa = '{16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0, 16'h1000};
    txn("tri");

    ia = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0, 0};
    qa = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 0, 0};
    txn("sat");

    ia = '{16'h1000, 0, 0, 16'h1000, 0, 16'h1000};
    qa = '{16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0, 16'h1000};
    err_in = 1'b1;
    txn("errin");
    err_in = 1'b0;

    for (int r = 0; r < 6; r++) begin
      rand_ops();
      txn($sformatf("rnd%0d", r));
    end
    err_in = 1'b0;

    rand_ops();
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    valid = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ainv11", int'(ao[0]), 0);
    chk("abort_Error", int'(Error), 0);
    n = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("abort_no_done", n, 0);
    rand_ops();
    txn("post_abort");

    rand_ops();
    calc_exp();
    valid = 1'b1;
    @(posedge clk); #1;
    rand_ops();
    n = 0;
    wait_done();
    chk("cont0_latency", n, 19);
    chk_out("cont0");
    for (int r = 1; r < 4; r++) begin
      calc_exp();
      @(posedge clk); #1;
      rand_ops();
      n = 1;
      wait_done();
      chk($sformatf("cont%0d_period", r), n, 20);
      chk_out($sformatf("cont%0d", r));
    end
    valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
